uart_tx_scheduler: RTL and testbench
====================================

// Module: uart_tx_scheduler
// PURPOSE
//   Shares the single UART transmit byte channel between NUM_REQ requesters (DMI TAP read-data stream,
//   TAP address/command notifications, future status sources). Grants whole frames round-robin, escapes
//   command bytes and in-band ESC data bytes, and paces writes to the transmitter. Sits between the
//   TAP-side TX ports and the UART transmitter FIFO.
// PARAMETERS
//   NUM_REQ    2      number of requesters, >=2
//   MAX_FRAME  16     max bytes per granted frame before forced release, >=1
//   ESC_BYTE   8'h1B  escape byte placed before every command byte and before data equal to ESC_BYTE
// PORTS
//   CLK_I         in   1          clock; all logic on rising edge
//   RST_I         in   1          synchronous reset, active-high
//   REQ_VALID_I   in   NUM_REQ    requester i offers a byte
//   REQ_CMD_I     in   NUM_REQ    offered byte is a command byte (gets escaped)
//   REQ_DATA_I    in   NUM_REQ*8  offered bytes, requester i at [8*i +: 8]
//   REQ_LAST_I    in   NUM_REQ    offered byte ends the frame
//   REQ_READY_O   out  NUM_REQ    byte of requester i consumed this cycle (comb.)
//   TX_READY_I    in   1          transmitter can take a byte
//   TX_WRITE_O    out  1          write strobe to transmitter (comb.)
//   TX_DATA_O     out  8          byte to transmitter (comb.)
//   GRANT_O       out  NUM_REQ    one-hot current owner, registered; 0 when idle
//   FRAME_ERR_O   out  1          one-cycle pulse: frame truncated at MAX_FRAME
// BEHAVIOUR
//   Reset: state IDLE, GRANT_O=0, rr_ptr=0 (requester 0 highest priority), esc_pending=0, byte_cnt=0,
//     holdoff=0, FRAME_ERR_O=0; TX_WRITE_O/REQ_READY_O are 0 since state is IDLE. Reset mid-frame drops the frame.
//   FSM states: IDLE, SEND, ESC.
//   IDLE: any REQ_VALID_I high -> winner = first valid index at or after rr_ptr (wrapping mod NUM_REQ);
//     GRANT_O<=onehot(winner), byte_cnt<=0, -> SEND. No bytes move in the arbitration cycle (1-cycle latency).
//   write_ok = TX_READY_I && !holdoff && REQ_VALID_I[g]; holdoff<=TX_WRITE_O (never two writes back to back,
//     covers the transmitter's one-cycle-late TX_READY_I drop).
//   SEND: needs_esc = REQ_CMD_I[g] || REQ_DATA_I[g]==ESC_BYTE.
//     write_ok && needs_esc -> TX_WRITE_O=1, TX_DATA_O=ESC_BYTE, REQ_READY_O[g]=0, -> ESC.
//     write_ok && !needs_esc -> TX_WRITE_O=1, TX_DATA_O=REQ_DATA_I[g], REQ_READY_O[g]=1, byte_cnt++ (consume).
//   ESC: write_ok -> TX_WRITE_O=1, TX_DATA_O=REQ_DATA_I[g], REQ_READY_O[g]=1, byte_cnt++ (consume), -> SEND.
//     Requester must hold byte/CMD stable once ESC was emitted; dropping valid in ESC stalls (no timeout).
//   Consume with REQ_LAST_I[g]: GRANT_O<=0, rr_ptr<=(g+1) mod NUM_REQ, -> IDLE.
//   Consume without LAST where byte_cnt reaches MAX_FRAME: same release, FRAME_ERR_O pulses next cycle.
//   LAST on the MAX_FRAME-th byte: normal release, no error.
//   Valid low mid-frame: grant held, nothing written. Other requesters' REQ_READY_O always 0.
//   byte_cnt width $clog2(MAX_FRAME+1); counts consumed payload bytes only, not ESC bytes.
//   Max throughput 1 payload byte per 2 cycles (1 per 4 when escaped).
// STRUCTURE
//   uart_pkg: ESC_BYTE default constant, tx_sched_state_t enum {IDLE,SEND,ESC}.
//   Sub-module rr_arbiter (NUM_REQ; req, ptr -> one-hot grant, index); rest is one FSM process.
// TESTING
//   Req0 frame {8'h41, 8'h42 LAST}, TX_READY_I=1 -> TX 41,42 on alternating cycles; GRANT_O=01 then 00.
//   Req0 cmd byte 8'h05 LAST -> TX 1B then 05, REQ_READY_O[0] only with 05; data 8'h1B -> TX 1B,1B.
//   Req0 and req1 valid continuously, 1-byte LAST frames -> grants 0,1,0,1; rr_ptr wraps.
//   Req1 3-byte frame while req0 raises valid mid-frame -> req1 finishes all 3 bytes before req0 granted.
//   MAX_FRAME=4, req0 sends 6 bytes no LAST -> 4 bytes out, FRAME_ERR_O pulse, req1 granted if valid.
//   TX_READY_I low 5 cycles mid-frame, then RST_I during ESC -> no writes while low; post-reset GRANT_O=0, IDLE.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit scheduler.
package uart_pkg;

  // Escape marker placed in front of command bytes and in-band escape data.
  localparam logic [7:0] ESC_BYTE_DEFAULT = 8'h1B;

  // Scheduler FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    ESC  = 2'd2
  } tx_sched_state_t;

  // Index of the requester after idx, wrapping at num_req.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned num_req);
    return (idx + 1 >= num_req) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/uart_tx_scheduler_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr_i,
// wrapping around, wins. Returns both a one-hot grant and its index.
module rr_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               any_o
);

  logic [2*NUM_REQ-1:0] req_dbl;
  logic [NUM_REQ-1:0]   req_rot;

  // Rotate so that bit 0 corresponds to the current priority pointer.
  assign req_dbl = {req_i, req_i} >> ptr_i;
  assign req_rot = req_dbl[NUM_REQ-1:0];

  // Find the first set bit of the rotated request, then map back to an index.
  always_comb begin
    logic [IDX_W:0] sum;
    any_o   = 1'b0;
    idx_o   = '0;
    grant_o = '0;
    sum     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!any_o && req_rot[k]) begin
        any_o = 1'b1;
        sum   = {1'b0, ptr_i} + (IDX_W+1)'(k);
        if (sum >= (IDX_W+1)'(NUM_REQ)) begin
          sum = sum - (IDX_W+1)'(NUM_REQ);
        end
        idx_o = sum[IDX_W-1:0];
      end
    end
    if (any_o) begin
      grant_o = NUM_REQ'(1) << idx_o;
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART transmit byte channel among NUM_REQ requesters.
// Whole frames are granted round-robin; command bytes and data bytes equal
// to ESC_BYTE are preceded by ESC_BYTE; writes are spaced at least one idle
// cycle apart so a late TX_READY_I drop from the transmitter is never missed.
//
//   state | meaning
//   IDLE  | no owner; arbitrate among valid requesters (no byte moves)
//   SEND  | owner granted; next write is escape marker or plain payload byte
//   ESC   | escape marker sent; next write is the held payload byte
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int         NUM_REQ   = 2,
  parameter int         MAX_FRAME = 16,
  parameter logic [7:0] ESC_BYTE  = ESC_BYTE_DEFAULT
) (
  input  logic                   CLK_I,
  input  logic                   RST_I,
  input  logic [NUM_REQ-1:0]     REQ_VALID_I,
  input  logic [NUM_REQ-1:0]     REQ_CMD_I,
  input  logic [NUM_REQ*8-1:0]   REQ_DATA_I,
  input  logic [NUM_REQ-1:0]     REQ_LAST_I,
  output logic [NUM_REQ-1:0]     REQ_READY_O,
  input  logic                   TX_READY_I,
  output logic                   TX_WRITE_O,
  output logic [7:0]             TX_DATA_O,
  output logic [NUM_REQ-1:0]     GRANT_O,
  output logic                   FRAME_ERR_O
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_FRAME + 1);

  tx_sched_state_t      state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]     gidx_q, gidx_d;
  logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]     byte_cnt_q, byte_cnt_d;
  logic                 holdoff_q, holdoff_d;
  logic                 frame_err_q, frame_err_d;

  logic [NUM_REQ-1:0]   arb_grant;
  logic [IDX_W-1:0]     arb_idx;
  logic                 arb_any;

  logic [7:0]           req_data [NUM_REQ];
  logic                 cur_valid, cur_cmd, cur_last;
  logic [7:0]           cur_data;
  logic                 write_ok, needs_esc, consume;
  logic [CNT_W-1:0]     cnt_inc;
  logic                 cnt_full;
  logic [IDX_W-1:0]     next_ptr;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req_i   (REQ_VALID_I),
    .ptr_i   (rr_ptr_q),
    .grant_o (arb_grant),
    .idx_o   (arb_idx),
    .any_o   (arb_any)
  );

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_split
    assign req_data[i] = REQ_DATA_I[8*i +: 8];
  end

  // Current owner's offer, escape decision and frame-length bookkeeping.
  always_comb begin
    cur_valid = REQ_VALID_I[gidx_q];
    cur_cmd   = REQ_CMD_I[gidx_q];
    cur_last  = REQ_LAST_I[gidx_q];
    cur_data  = req_data[gidx_q];
    write_ok  = TX_READY_I && !holdoff_q && cur_valid;
    needs_esc = cur_cmd || (cur_data == ESC_BYTE);
    cnt_inc   = byte_cnt_q + CNT_W'(1);
    cnt_full  = (cnt_inc == CNT_W'(MAX_FRAME));
    next_ptr  = IDX_W'(rr_next(32'(gidx_q), NUM_REQ));
  end

  // Next-state and output decode for the scheduler FSM.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    gidx_d      = gidx_q;
    rr_ptr_d    = rr_ptr_q;
    byte_cnt_d  = byte_cnt_q;
    frame_err_d = 1'b0;
    consume     = 1'b0;
    TX_WRITE_O  = 1'b0;
    TX_DATA_O   = '0;
    REQ_READY_O = '0;

    case (state_q)
      IDLE: begin
        if (arb_any) begin
          grant_d    = arb_grant;
          gidx_d     = arb_idx;
          byte_cnt_d = '0;
          state_d    = SEND;
        end
      end
      SEND: begin
        if (write_ok) begin
          TX_WRITE_O = 1'b1;
          if (needs_esc) begin
            TX_DATA_O = ESC_BYTE;
            state_d   = ESC;
          end else begin
            TX_DATA_O = cur_data;
            consume   = 1'b1;
          end
        end
      end
      ESC: begin
        // Payload must be held stable by the requester; a dropped valid just stalls here.
        if (write_ok) begin
          TX_WRITE_O = 1'b1;
          TX_DATA_O  = cur_data;
          consume    = 1'b1;
          state_d    = SEND;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase

    if (consume) begin
      REQ_READY_O = grant_q;
      byte_cnt_d  = cnt_inc;
      if (cur_last || cnt_full) begin
        // A LAST on the final allowed byte is a clean end, not a truncation.
        grant_d     = '0;
        rr_ptr_d    = next_ptr;
        state_d     = IDLE;
        frame_err_d = !cur_last;
      end
    end

    holdoff_d = TX_WRITE_O;
  end

  assign GRANT_O     = grant_q;
  assign FRAME_ERR_O = frame_err_q;

  // State registers with synchronous reset; reset drops any frame in flight.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      gidx_q      <= '0;
      rr_ptr_q    <= '0;
      byte_cnt_q  <= '0;
      holdoff_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      gidx_q      <= gidx_d;
      rr_ptr_q    <= rr_ptr_d;
      byte_cnt_q  <= byte_cnt_d;
      holdoff_q   <= holdoff_d;
      frame_err_q <= frame_err_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Scoreboard bench for uart_tx_scheduler (NUM_REQ=2, MAX_FRAME=4).
module tb_uart_tx_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid, req_cmd, req_last, req_ready, grant;
  logic [15:0] req_data;
  logic        tx_ready, tx_write, frame_err;
  logic [7:0]  tx_data;

  always #5 clk = ~clk;

  uart_tx_scheduler #(
    .NUM_REQ   (2),
    .MAX_FRAME (4),
    .ESC_BYTE  (8'h1B)
  ) dut (
    .CLK_I       (clk),
    .RST_I       (rst),
    .REQ_VALID_I (req_valid),
    .REQ_CMD_I   (req_cmd),
    .REQ_DATA_I  (req_data),
    .REQ_LAST_I  (req_last),
    .REQ_READY_O (req_ready),
    .TX_READY_I  (tx_ready),
    .TX_WRITE_O  (tx_write),
    .TX_DATA_O   (tx_data),
    .GRANT_O     (grant),
    .FRAME_ERR_O (frame_err)
  );

  typedef struct packed {
    logic       cmd;
    logic [7:0] data;
    logic       last;
  } item_t;

  typedef struct packed {
    logic [7:0] data;
    logic [1:0] owner_oh;
    logic       rdy;
  } exp_t;

  item_t rq [2][$];
  exp_t  exp_q [$];
  int    n_cmp = 0;
  int    n_bad = 0;
  int    err_seen = 0;
  int    err_exp = 0;
  logic [1:0] cons;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timed out waiting (t=%0t)", name, $time);
  endtask

  task automatic push(input int r, input logic c, input logic [7:0] d, input logic l);
    item_t it;
    it.cmd  = c;
    it.data = d;
    it.last = l;
    rq[r].push_back(it);
  endtask

  task automatic expect_tx(input logic [7:0] d, input int owner, input logic rdy);
    exp_t e;
    e.data     = d;
    e.owner_oh = (owner == 0) ? 2'b01 : 2'b10;
    e.rdy      = rdy;
    exp_q.push_back(e);
  endtask

  task automatic wait_idle(input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk); #2;
      if (rq[0].size() == 0 && rq[1].size() == 0 && exp_q.size() == 0 && grant == 2'b00)
        done = 1'b1;
    end
    if (!done) fail_now({name, "_idle"});
    repeat (3) @(negedge clk);
    #2;
    chk({name, "_grant_idle"}, 32'(grant), 32'h0);
    chk({name, "_exp_drained"}, 32'(exp_q.size()), 32'h0);
    chk({name, "_frame_err_count"}, 32'(err_seen), 32'(err_exp));
  endtask

  // Requester model: present queue heads, retire a byte once it was consumed.
  initial begin
    cons      = 2'b00;
    req_valid = 2'b00;
    req_cmd   = 2'b00;
    req_last  = 2'b00;
    req_data  = 16'h0000;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (cons[i] && rq[i].size() > 0) void'(rq[i].pop_front());
      end
      for (int i = 0; i < 2; i++) begin
        if (rq[i].size() > 0) begin
          req_valid[i]       = 1'b1;
          req_cmd[i]         = rq[i][0].cmd;
          req_last[i]        = rq[i][0].last;
          req_data[8*i +: 8] = rq[i][0].data;
        end else begin
          req_valid[i]       = 1'b0;
          req_cmd[i]         = 1'b0;
          req_last[i]        = 1'b0;
          req_data[8*i +: 8] = 8'h00;
        end
      end
      #4;
      cons = req_ready;
    end
  end

  // Monitor: compare every transmitter write against the scoreboard.
  initial begin
    exp_t e;
    logic prev_write, prev_err;
    prev_write = 1'b0;
    prev_err   = 1'b0;
    forever begin
      @(negedge clk); #4;
      if (!rst) begin
        if (tx_write) begin
          chk("tx_ready_at_write", 32'(tx_ready), 32'h1);
          chk("no_back_to_back", 32'(prev_write), 32'h0);
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_write: got %0h expected no write (t=%0t)", tx_data, $time);
          end else begin
            e = exp_q.pop_front();
            chk("tx_data", 32'(tx_data), 32'(e.data));
            chk("grant_at_write", 32'(grant), 32'(e.owner_oh));
            chk("req_ready", 32'(req_ready), e.rdy ? 32'(e.owner_oh) : 32'h0);
          end
        end else begin
          chk("req_ready_no_write", 32'(req_ready), 32'h0);
        end
        if (frame_err) begin
          err_seen++;
          chk("frame_err_one_cycle", 32'(prev_err), 32'h0);
        end
      end
      prev_write = tx_write;
      prev_err   = frame_err;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got no end of test expected end before limit");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    bit seen;
    rst      = 1'b1;
    tx_ready = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_tx_write", 32'(tx_write), 32'h0);
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    chk("rst_frame_err", 32'(frame_err), 32'h0);
    @(negedge clk); #1;
    rst = 1'b0;

    // Plain two-byte frame from requester 0.
    @(negedge clk); #2;
    expect_tx(8'h41, 0, 1'b1);
    expect_tx(8'h42, 0, 1'b1);
    push(0, 1'b0, 8'h41, 1'b0);
    push(0, 1'b0, 8'h42, 1'b1);
    wait_idle("t1_plain");

    // Command byte is escaped; ready only with the payload.
    expect_tx(8'h1B, 0, 1'b0);
    expect_tx(8'h05, 0, 1'b1);
    push(0, 1'b1, 8'h05, 1'b1);
    wait_idle("t2_cmd");

    // In-band escape data is escaped too.
    expect_tx(8'h1B, 0, 1'b0);
    expect_tx(8'h1B, 0, 1'b1);
    push(0, 1'b0, 8'h1B, 1'b1);
    wait_idle("t3_escdata");

    // Both requesters continuously valid; rr_ptr is 1 here so req1 leads.
    expect_tx(8'h20, 1, 1'b1);
    expect_tx(8'h10, 0, 1'b1);
    expect_tx(8'h21, 1, 1'b1);
    expect_tx(8'h11, 0, 1'b1);
    push(0, 1'b0, 8'h10, 1'b1);
    push(0, 1'b0, 8'h11, 1'b1);
    push(1, 1'b0, 8'h20, 1'b1);
    push(1, 1'b0, 8'h21, 1'b1);
    wait_idle("t4_alternate");

    // Req1 frame is not preempted by req0 raising valid mid-frame.
    expect_tx(8'h30, 1, 1'b1);
    expect_tx(8'h31, 1, 1'b1);
    expect_tx(8'h32, 1, 1'b1);
    expect_tx(8'h40, 0, 1'b1);
    push(1, 1'b0, 8'h30, 1'b0);
    push(1, 1'b0, 8'h31, 1'b0);
    push(1, 1'b0, 8'h32, 1'b1);
    repeat (4) @(negedge clk);
    #2;
    push(0, 1'b0, 8'h40, 1'b1);
    wait_idle("t5_nopreempt");

    // Overlong frame truncated at 4 bytes; req1 then gets its turn.
    err_exp++;
    expect_tx(8'h50, 0, 1'b1);
    expect_tx(8'h51, 0, 1'b1);
    expect_tx(8'h52, 0, 1'b1);
    expect_tx(8'h53, 0, 1'b1);
    expect_tx(8'h60, 1, 1'b1);
    expect_tx(8'h54, 0, 1'b1);
    expect_tx(8'h55, 0, 1'b1);
    expect_tx(8'h56, 0, 1'b1);
    for (int b = 0; b < 6; b++) push(0, 1'b0, 8'h50 + 8'(b), 1'b0);
    push(0, 1'b0, 8'h56, 1'b1);
    repeat (3) @(negedge clk);
    #2;
    push(1, 1'b0, 8'h60, 1'b1);
    wait_idle("t6_truncate");

    // LAST exactly on the 4th byte: clean release, no error.
    for (int b = 0; b < 4; b++) begin
      expect_tx(8'h70 + 8'(b), 0, 1'b1);
      push(0, 1'b0, 8'h70 + 8'(b), (b == 3));
    end
    wait_idle("t7_last_at_max");

    // Transmitter back-pressure mid-frame, then reset while in ESC.
    expect_tx(8'h80, 0, 1'b1);
    expect_tx(8'h81, 0, 1'b1);
    expect_tx(8'h1B, 0, 1'b0);
    push(0, 1'b0, 8'h80, 1'b0);
    push(0, 1'b0, 8'h81, 1'b0);
    push(0, 1'b1, 8'h82, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk); #4;
      if (tx_write && tx_data == 8'h80) seen = 1'b1;
    end
    if (!seen) fail_now("t8_first_write");
    @(negedge clk);
    tx_ready = 1'b0;
    repeat (5) @(negedge clk);
    tx_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk); #4;
      if (tx_write && tx_data == 8'h1B) seen = 1'b1;
    end
    if (!seen) fail_now("t8_esc_write");
    @(negedge clk);
    rst      = 1'b1;
    tx_ready = 1'b0;
    @(negedge clk); #2;
    chk("t8_rst_grant", 32'(grant), 32'h0);
    chk("t8_rst_tx_write", 32'(tx_write), 32'h0);
    chk("t8_rst_req_ready", 32'(req_ready), 32'h0);
    chk("t8_rst_exp_drained", 32'(exp_q.size()), 32'h0);
    rq[0].delete();
    rq[1].delete();
    exp_q.delete();
    @(negedge clk); #1;
    rst      = 1'b0;
    tx_ready = 1'b1;
    #1;
    chk("t8_post_rst_grant", 32'(grant), 32'h0);
    chk("t8_post_rst_frame_err", 32'(frame_err), 32'h0);

    // After reset rr_ptr is back at 0: req0 wins a simultaneous request.
    @(negedge clk); #2;
    expect_tx(8'hA0, 0, 1'b1);
    expect_tx(8'hB0, 1, 1'b1);
    push(0, 1'b0, 8'hA0, 1'b1);
    push(1, 1'b0, 8'hB0, 1'b1);
    wait_idle("t9_rr_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
